// File: rtl/count_display_pkg.sv
// count_display_pkg: shared 7-segment patterns, digit-enable patterns, converter states and double-dabble step
package count_display_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [3:0] AN_UNITS = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction
  // One double-dabble step on {tens, units, bin[4:0]}: add 3 to nibbles >= 5, then shift left.
  function automatic logic [12:0] dabble(input logic [12:0] s);
    logic [12:0] a;
    a = s;
    if (a[8:5] >= 4'd5) a[8:5] = a[8:5] + 4'd3;
    if (a[12:9] >= 4'd5) a[12:9] = a[12:9] + 4'd3;
    return {a[11:0], 1'b0};
  endfunction
endpackage

// File: rtl/count_display_if.sv
// count_display_if: counter inputs and display outputs of count_display; master = driver/observer, slave = display block
interface count_display_if;
  logic [4:0] Q;
  logic       C;
  logic       CLR_CARRY;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       DP;
  logic       CARRY_LED;
  logic       BUSY;
  modport master (output Q, C, CLR_CARRY, input SEG, AN, DP, CARRY_LED, BUSY);
  modport slave (input Q, C, CLR_CARRY, output SEG, AN, DP, CARRY_LED, BUSY);
endinterface

// File: rtl/bin2bcd5.sv
// bin2bcd5: 5-bit binary to two BCD digits, one double-dabble step per cycle; ports clk, rst (async high), start, din, busy, done, tens, units
module bin2bcd5
  import count_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] din,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);
  state_t state, state_n;
  logic [12:0] sr;
  logic [2:0] cnt;
  always_comb begin
    state_n = IDLE;
    busy = state != IDLE;
    done = state == DONE;
    state_n = (state == IDLE) ? (start ? SHIFT : IDLE) :
              (state == SHIFT) ? (cnt == 3'd4 ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sr <= {8'd0, din};
        cnt <= '0;
      end
      if (state == SHIFT) begin
        sr <= dabble(sr);
        cnt <= cnt + 3'd1;
      end
    end
  assign tens = sr[12:9];
  assign units = sr[8:5];
endmodule

// File: rtl/count_display.sv
// count_display: 2-digit multiplexed 7-segment display of a 5-bit count with sticky carry LED
// Ports: CLK, RST (async active-high), bus (count_display_if.slave: Q, C, CLR_CARRY in; SEG, AN, DP, CARRY_LED, BUSY out)
// Parameter SCAN_DIV: clock cycles per digit slot. Macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic CLK,
  input  logic RST,
  count_display_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [4:0] q_r, last;
  logic [PW-1:0] presc;
  logic sel, carry, busy, done, start;
  logic [3:0] tens, units, tens_c, units_c;
  logic [6:0] seg, seg_n;
  logic [3:0] an;
  // Start only from IDLE; a changed Q_r seen while busy is picked up once the converter is idle again.
  assign start = q_r != last;
  bin2bcd5 u_conv (
    .clk(CLK), .rst(RST), .start(start), .din(q_r),
    .busy(busy), .done(done), .tens(tens_c), .units(units_c)
  );
  always_comb begin
    seg_n = seg_decode(sel ? tens : units);
`ifdef LEADING_ZERO_BLANK_EN
    seg_n = (sel && tens == 4'd0) ? SEG_BLANK : seg_n;
`endif
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      q_r <= '0;
      last <= '0;
      tens <= '0;
      units <= '0;
      presc <= '0;
      sel <= 1'b0;
      carry <= 1'b0;
      seg <= SEG_BLANK;
      an <= AN_OFF;
    end else begin
      q_r <= bus.Q;
      last <= (!busy && start) ? q_r : last;
      tens <= done ? tens_c : tens;
      units <= done ? units_c : units;
      presc <= (presc == PW'(SCAN_DIV - 1)) ? '0 : presc + 1'b1;
      sel <= (presc == PW'(SCAN_DIV - 1)) ? ~sel : sel;
      carry <= bus.C ? 1'b1 : bus.CLR_CARRY ? 1'b0 : carry;
      seg <= seg_n;
      an <= sel ? AN_TENS : AN_UNITS;
    end
  assign bus.SEG = seg;
  assign bus.AN = an;
  assign bus.DP = 1'b1;
  assign bus.CARRY_LED = carry;
  assign bus.BUSY = busy;
endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit-scan slot (1 kHz at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port CLK, input, 1, system clock; all state changes on the rising edge.
REQ-003 SHALL have port RST, input, 1, reset; reset is asynchronous and active-high.
REQ-004 SHALL have port Q, input, 5, binary count from the upstream 5-bit counter, range 0..31.
REQ-005 SHALL have port C, input, 1, carry pulse from the upstream counter.
REQ-006 SHALL have port CLR_CARRY, input, 1, synchronous clear of the sticky carry flag.
REQ-007 SHALL have port SEG, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-008 SHALL have port AN, output, 4, active-low digit enables; AN[3:2] always 1.
REQ-009 SHALL have port DP, output, 1, active-low decimal point; constant 1 (off).
REQ-010 SHALL have port CARRY_LED, output, 1, sticky carry indicator.
REQ-011 SHALL have port BUSY, output, 1, high while a binary-to-BCD conversion is in progress.

Function
REQ-012 SHALL register Q into Q_r every edge; Q_r is the only copy of Q used internally.
REQ-013 SHALL run converter FSM states IDLE, SHIFT, DONE; IDLE->SHIFT when Q_r != LAST, loading LAST<=Q_r and the shift register.
REQ-014 SHALL perform in SHIFT exactly 5 double-dabble steps (add 3 to any BCD nibble >=5, then shift left 1), one per cycle, then go to DONE.
REQ-015 SHALL in DONE write TENS and UNITS digit registers together, then return to IDLE; no partial-digit state visible on SEG.
REQ-016 SHALL have latency: Q_r sampled at edge k -> digit registers updated at edge k+7; BUSY high after edges k+1..k+6, low after k+7.
REQ-017 SHALL ignore Q_r changes during SHIFT/DONE; the newer value is converted on return to IDLE (retrigger next edge).
REQ-018 SHALL convert all 32 input values correctly (0..31 -> TENS 0..3, UNITS 0..9).
REQ-019 SHALL run a prescaler 0..SCAN_DIV-1; on terminal count, toggle digit select SEL and wrap prescaler to 0.
REQ-020 SHALL drive AN=4'b1110 with UNITS decode when SEL=0, AN=4'b1101 with TENS decode when SEL=1; SEG and AN change on the same edge.
REQ-021 SHALL decode digits 0..9 to standard active-low patterns (0=7'b1000000, 1=7'b1111001, 3=7'b0110000, 7=7'b1111000).
REQ-022 SHALL set CARRY_LED on any edge where C=1; clear it on CLR_CARRY=1; set wins when both are high.

Reset
REQ-023 SHALL on RST=1, without waiting for a clock: FSM=IDLE, Q_r=LAST=0, TENS=UNITS=0, prescaler=0, SEL=0, CARRY_LED=0, BUSY=0, SEG=7'h7F, AN=4'hF, DP=1.
REQ-024 SHALL abort any conversion on reset mid-operation; the first edge after RST falls samples Q, and conversion starts only if Q!=0.

Configuration
REQ-025 SHALL, with LEADING_ZERO_BLANK_EN defined, drive SEG=7'h7F during the tens slot when TENS=0 (AN still 4'b1101).
REQ-026 SHALL, without LEADING_ZERO_BLANK_EN, display TENS=0 as 7'b1000000.

Structure
REQ-027 SHALL place the 7-segment digit patterns, blank pattern 7'h7F, AN patterns and FSM state encodings in shared package count_display_pkg.
REQ-028 SHALL implement the converter FSM as sub-module bin2bcd5 (start, 5-bit in, busy, done, two 4-bit digits out); scan and carry logic stay in count_display.

Verification (SCAN_DIV=4)
REQ-029 SHALL check: RST asserted mid-conversion between clock edges -> all outputs at REQ-023 values immediately; BUSY=0.
REQ-030 SHALL check: Q=17 from reset -> BUSY high 6 cycles, then AN alternates 1110/1101 every 4 cycles with SEG=7'b1111000 / 7'b1111001.
REQ-031 SHALL check: Q=31 -> digits 3,1; Q=0 after 31 -> TENS 0 shown as 7'h7F (macro on) or 7'b1000000 (macro off).
REQ-032 SHALL check: Q=5, then Q=9 on the third cycle of BUSY -> display 5 first, second conversion starts one edge after DONE, final display 9.
REQ-033 SHALL check: 1-cycle C pulse -> CARRY_LED=1 held for 100 cycles; CLR_CARRY pulse -> 0; C and CLR_CARRY together -> 1.
